loader_bridge: RTL and testbench
================================

# loader_bridge

Write-staging stage between `data_io` and the SDRAM loader port. Accepts ioctl bytes during an OSD download and remaps ROM-image addresses into the SDRAM ROM/sideways areas. Buffers them in a small FIFO and issues at most one SDRAM write per `mem_sync` slot. CMOS images (index 8'hff) are diverted to the CMOS RAM write port and never queued.

## Interface

Parameters:

- `FIFO_DEPTH`, 4 — entries in the write FIFO; power of two, ≥2.
- `ROM_BASE`, 25'h080000 — SDRAM offset added when `ioctl_index == 0` (MOS/ROM bundle).
- `SWR_BASE`, 25'h068000 — SDRAM offset added for any other index except 8'hff (sideways/extra images).

Ports (`name direction width meaning`):

- `clk_sys` in 1 — system clock (48 MHz); all logic on its rising edge.
- `reset_n` in 1 — synchronous, active-low reset.
- `ioctl_download` in 1 — download in progress.
- `ioctl_index` in 8 — image index of current download.
- `ioctl_wr` in 1 — one-cycle byte strobe.
- `ioctl_addr` in 25 — byte address within image.
- `ioctl_dout` in 8 — byte data.
- `mem_sync` in 1 — one-cycle SDRAM slot strobe; a new request is latched on this cycle.
- `loader_we` out 1 — SDRAM write request, held for a whole slot.
- `loader_addr` out 25 — SDRAM byte address.
- `loader_data` out 8 — SDRAM write data.
- `cmos_we` out 1 — one-cycle CMOS write pulse.
- `cmos_addr` out 7 — CMOS address.
- `cmos_data` out 8 — CMOS data.
- `busy` out 1 — `ioctl_download | fifo_not_empty | loader_we`; drives the SDRAM address mux select and core reset.
- `overflow` out 1 — sticky: a byte was dropped on a full FIFO.

## Operation

- Accept condition is `ioctl_wr & ioctl_download`. Strobes while `ioctl_download` is low are ignored.
- CMOS path, when `ioctl_index == 8'hff`:
  - Next cycle: `cmos_we=1`, `cmos_addr=ioctl_addr[6:0]`, `cmos_data=ioctl_dout`, for one cycle only.
  - Nothing is queued; `busy` is unaffected beyond `ioctl_download`.
- ROM path, for any other index:
  - Push `{ioctl_addr + base, ioctl_dout}`. `base` is `ROM_BASE` when index is 0, otherwise `SWR_BASE`.
  - The sum is 25-bit, modulo 2^25; carry is discarded.
  - Address is computed at push time. Later index changes do not affect queued entries.
- FIFO:
  - Circular buffer with read/write pointers and a count.
  - Push when full: byte dropped, `overflow` set, FIFO unchanged.
  - `overflow` clears on reset or on the rising edge of `ioctl_download`.
- Slot issue, evaluated only on cycles with `mem_sync=1`:
  - FIFO not empty: pop head; next cycle `loader_we=1`, `loader_addr`/`loader_data` = head.
  - FIFO empty: next cycle `loader_we=0`; `loader_addr`/`loader_data` hold their last values.
  - Outputs change only on the cycle after `mem_sync`, and are stable for the full slot.
- Push and pop in the same cycle:
  - Both take effect; count is unchanged.
  - The pop decision uses the pre-push count. A byte pushed into an empty FIFO in the `mem_sync` cycle is issued at the following `mem_sync`.
  - A push while full that coincides with a pop is accepted, not dropped (count after pop < depth).
- End of download:
  - `ioctl_download` falling does not flush the FIFO. Remaining entries drain one per slot.
  - `busy` deasserts on the cycle after the slot in which `loader_we` returns to 0 with the FIFO empty.
- Reset (`reset_n=0` at a clock edge):
  - Pointers/count cleared.
  - `loader_we`, `cmos_we`, `overflow` = 0; `loader_addr`, `loader_data`, `cmos_addr`, `cmos_data` = 0.
  - `busy` reflects only `ioctl_download`.
  - Mid-drain reset discards queued entries and aborts the current request on the next cycle.

## Timing

- All outputs registered except `busy`, which is combinational from registered state and `ioctl_download`.
- CMOS latency: `cmos_we` high exactly 1 cycle after the accepted strobe.
- SDRAM latency: byte accepted at cycle t, FIFO previously empty, next `mem_sync` at t+k (k≥1) → `loader_we` high from t+k+1 until the cycle after the next `mem_sync`.
- Throughput: one byte per `mem_sync` period. No loss while `ioctl_wr` rate ≤ slot rate, or while bursts ≤ `FIFO_DEPTH`.
- Back-to-back `mem_sync` on consecutive cycles is legal: one pop per strobe.

## Test plan

- Index 0, addr 25'h000010, data 8'hA5, `mem_sync` every 8 cycles → one slot with `loader_we=1`, `loader_addr=25'h080010`, `loader_data=8'hA5`; `busy` drops after the following slot.
- Index 8'h01, addr 25'h001FFF → `loader_addr=25'h069FFF`. Index 0 with addr 25'h1FFFFFF → wraps to 25'h07FFFF.
- Index 8'hff, addr 25'h0000C3, data 8'h5A → `cmos_we` single pulse, `cmos_addr=7'h43`, `cmos_data=8'h5A`; `loader_we` stays 0.
- Burst of 6 consecutive strobes (data 1..6), depth 4, no `mem_sync` → bytes 5 and 6 dropped, `overflow=1`; four slots then issue 1,2,3,4 in order; new download rising edge clears `overflow`.
- Strobe into an empty FIFO in the same cycle as `mem_sync` → no write in that slot; byte issued at the next `mem_sync`.
- Three bytes queued, assert `reset_n=0` mid-slot → next cycle `loader_we=0`, `busy` = `ioctl_download`, no further writes after release.

Source files
------------

// File: rtl/loader_bridge_if.sv
// Bundle between data_io, the loader bridge and the SDRAM/CMOS write ports.
// slave is the bridge's view; master is the driving side (data_io, sdram mux).
interface loader_bridge_if;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        mem_sync;
  logic        loader_we;
  logic [24:0] loader_addr;
  logic [7:0]  loader_data;
  logic        cmos_we;
  logic [6:0]  cmos_addr;
  logic [7:0]  cmos_data;
  logic        busy;
  logic        overflow;

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, mem_sync,
    output loader_we, loader_addr, loader_data, cmos_we, cmos_addr, cmos_data,
           busy, overflow
  );

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, mem_sync,
    input  loader_we, loader_addr, loader_data, cmos_we, cmos_addr, cmos_data,
           busy, overflow
  );
endinterface

// File: rtl/loader_bridge.sv
// Stages ioctl download bytes into a small FIFO and issues one SDRAM write per
// mem_sync slot; CMOS images (index 8'hff) go straight to the CMOS write port.
module loader_bridge #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [24:0] ROM_BASE   = 25'h080000,
  parameter logic [24:0] SWR_BASE   = 25'h068000
) (
  input logic             clk_sys,
  input logic             reset_n,
  loader_bridge_if.slave  bus
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [32:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          download_q;

  logic          accept;
  logic          is_cmos;
  logic          push_req;
  logic          push_ok;
  logic          pop;
  logic          full;
  logic [24:0]   push_addr;

  assign accept    = bus.ioctl_wr & bus.ioctl_download;
  assign is_cmos   = (bus.ioctl_index == 8'hff);
  assign push_req  = accept & ~is_cmos;
  assign full      = (count == CW'(FIFO_DEPTH));
  // Pop decision uses the pre-push count, so a byte landing in an empty FIFO
  // on the mem_sync cycle waits for the next slot.
  assign pop       = bus.mem_sync & (count != '0);
  assign push_ok   = push_req & (~full | pop);
  assign push_addr = bus.ioctl_addr + ((bus.ioctl_index == 8'h00) ? ROM_BASE : SWR_BASE);

  assign bus.busy  = bus.ioctl_download | (count != '0) | bus.loader_we;

  always_ff @(posedge clk_sys) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= {push_addr, bus.ioctl_dout};
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      download_q <= 1'b0;
      bus.overflow <= 1'b0;
    end else begin
      download_q <= bus.ioctl_download;
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // A drop on the very cycle a new download starts still latches.
      if (push_req & ~push_ok) begin
        bus.overflow <= 1'b1;
      end else if (bus.ioctl_download & ~download_q) begin
        bus.overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      bus.loader_we   <= 1'b0;
      bus.loader_addr <= '0;
      bus.loader_data <= '0;
    end else if (bus.mem_sync) begin
      bus.loader_we <= pop;
      if (pop) begin
        {bus.loader_addr, bus.loader_data} <= fifo_mem[rd_ptr];
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      bus.cmos_we   <= 1'b0;
      bus.cmos_addr <= '0;
      bus.cmos_data <= '0;
    end else begin
      bus.cmos_we <= accept & is_cmos;
      if (accept & is_cmos) begin
        bus.cmos_addr <= bus.ioctl_addr[6:0];
        bus.cmos_data <= bus.ioctl_dout;
      end
    end
  end

endmodule

// File: tb/tb_loader_bridge.sv
// Directed bench for loader_bridge: address remap, CMOS diversion, overflow,
// same-cycle push/slot ordering and mid-drain reset.
module tb_loader_bridge;

  logic clk_sys = 1'b0;
  logic reset_n;
  int   tests = 0;
  int   fails = 0;

  loader_bridge_if bus ();

  loader_bridge dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n clocks; inputs/outputs are touched 1ns after the rising edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic strobe(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] dat);
    bus.ioctl_index = idx;
    bus.ioctl_addr  = addr;
    bus.ioctl_dout  = dat;
    bus.ioctl_wr    = 1'b1;
    cyc(1);
    bus.ioctl_wr    = 1'b0;
  endtask

  task automatic slot();
    bus.mem_sync = 1'b1;
    cyc(1);
    bus.mem_sync = 1'b0;
  endtask

  initial begin
    reset_n            = 1'b0;
    bus.ioctl_download = 1'b0;
    bus.ioctl_index    = 8'h00;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    bus.mem_sync       = 1'b0;
    cyc(3);
    check("rst_loader_we", 32'(bus.loader_we), 32'h0);
    check("rst_loader_addr", 32'(bus.loader_addr), 32'h0);
    check("rst_cmos_we", 32'(bus.cmos_we), 32'h0);
    check("rst_overflow", 32'(bus.overflow), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    reset_n = 1'b1;
    cyc(2);

    // Single ROM byte, slot period of 8
    bus.ioctl_download = 1'b1;
    strobe(8'h00, 25'h000010, 8'hA5);
    check("rom_busy", 32'(bus.busy), 32'h1);
    check("rom_we_early", 32'(bus.loader_we), 32'h0);
    cyc(3);
    check("rom_we_before_slot", 32'(bus.loader_we), 32'h0);
    slot();
    check("rom_we", 32'(bus.loader_we), 32'h1);
    check("rom_addr", 32'(bus.loader_addr), 32'h080010);
    check("rom_data", 32'(bus.loader_data), 32'hA5);
    cyc(7);
    check("rom_we_held", 32'(bus.loader_we), 32'h1);
    bus.ioctl_download = 1'b0;
    check("rom_busy_tail", 32'(bus.busy), 32'h1);
    slot();
    check("rom_we_end", 32'(bus.loader_we), 32'h0);
    check("rom_addr_hold", 32'(bus.loader_addr), 32'h080010);
    check("rom_busy_end", 32'(bus.busy), 32'h0);

    // Strobe outside a download is ignored
    strobe(8'h00, 25'h000020, 8'h77);
    slot();
    check("nodl_we", 32'(bus.loader_we), 32'h0);
    check("nodl_busy", 32'(bus.busy), 32'h0);

    // Sideways base and 25-bit wrap
    bus.ioctl_download = 1'b1;
    strobe(8'h01, 25'h001FFF, 8'h11);
    slot();
    check("swr_addr", 32'(bus.loader_addr), 32'h069FFF);
    check("swr_data", 32'(bus.loader_data), 32'h11);
    strobe(8'h00, 25'h1FFFFFF, 8'h22);
    slot();
    check("wrap_addr", 32'(bus.loader_addr), 32'h07FFFF);
    check("wrap_data", 32'(bus.loader_data), 32'h22);
    slot();
    check("wrap_we_end", 32'(bus.loader_we), 32'h0);

    // CMOS diversion
    strobe(8'hff, 25'h0000C3, 8'h5A);
    check("cmos_we", 32'(bus.cmos_we), 32'h1);
    check("cmos_addr", 32'(bus.cmos_addr), 32'h43);
    check("cmos_data", 32'(bus.cmos_data), 32'h5A);
    cyc(1);
    check("cmos_we_pulse", 32'(bus.cmos_we), 32'h0);
    slot();
    check("cmos_no_sdram", 32'(bus.loader_we), 32'h0);
    bus.ioctl_download = 1'b0;
    cyc(1);
    check("cmos_busy", 32'(bus.busy), 32'h0);

    // Six-byte burst into a depth-4 FIFO
    bus.ioctl_download = 1'b1;
    bus.ioctl_index    = 8'h00;
    bus.ioctl_wr       = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      bus.ioctl_addr = 25'(i);
      bus.ioctl_dout = 8'(i);
      cyc(1);
    end
    bus.ioctl_wr = 1'b0;
    check("ovf_set", 32'(bus.overflow), 32'h1);
    for (int i = 1; i <= 4; i++) begin
      slot();
      check("burst_we", 32'(bus.loader_we), 32'h1);
      check("burst_data", 32'(bus.loader_data), 32'(i));
      check("burst_addr", 32'(bus.loader_addr), 32'h080000 + 32'(i));
      cyc(2);
    end
    slot();
    check("burst_dropped", 32'(bus.loader_we), 32'h0);
    check("ovf_sticky", 32'(bus.overflow), 32'h1);
    bus.ioctl_download = 1'b0;
    cyc(2);
    bus.ioctl_download = 1'b1;
    cyc(1);
    check("ovf_clear", 32'(bus.overflow), 32'h0);

    // Push into empty FIFO on the mem_sync cycle
    bus.ioctl_index  = 8'h00;
    bus.ioctl_addr   = 25'h000040;
    bus.ioctl_dout   = 8'h3C;
    bus.ioctl_wr     = 1'b1;
    bus.mem_sync     = 1'b1;
    cyc(1);
    bus.ioctl_wr     = 1'b0;
    bus.mem_sync     = 1'b0;
    check("same_cyc_we", 32'(bus.loader_we), 32'h0);
    cyc(3);
    slot();
    check("same_cyc_next_we", 32'(bus.loader_we), 32'h1);
    check("same_cyc_addr", 32'(bus.loader_addr), 32'h080040);
    check("same_cyc_data", 32'(bus.loader_data), 32'h3C);
    slot();

    // Mid-drain reset
    strobe(8'h00, 25'h000001, 8'hE1);
    strobe(8'h00, 25'h000002, 8'hE2);
    strobe(8'h00, 25'h000003, 8'hE3);
    slot();
    check("pre_rst_we", 32'(bus.loader_we), 32'h1);
    cyc(2);
    reset_n = 1'b0;
    cyc(1);
    check("mid_rst_we", 32'(bus.loader_we), 32'h0);
    check("mid_rst_busy_dl", 32'(bus.busy), 32'h1);
    bus.ioctl_download = 1'b0;
    #1;
    check("mid_rst_busy_nodl", 32'(bus.busy), 32'h0);
    cyc(1);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      slot();
      check("post_rst_we", 32'(bus.loader_we), 32'h0);
      cyc(1);
    end
    check("post_rst_busy", 32'(bus.busy), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
